// File: rtl/mem_arb_n.sv
// N-client SDT memory arbiter with fixed-priority / round-robin arbitration and an APB config port.
// Optional build macro MEM_ARB_N_STATS_EN adds per-client grant counters at 0x10 + 4*i.
module mem_arb_n #(
  parameter int CLIENTS    = 4,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             stable,
  input  logic                             conf_wr,
  input  logic                             conf_sel,
  input  logic                             conf_enable,
  input  logic [31:0]                      conf_addr,
  input  logic [31:0]                      conf_wdata,
  input  logic [3:0]                       conf_strb,
  output logic [31:0]                      conf_rdata,
  output logic                             conf_ready,
  output logic                             conf_slverr,
  input  logic [CLIENTS-1:0]               c_rd,
  input  logic [CLIENTS-1:0]               c_wr,
  input  logic [CLIENTS*ADDR_WIDTH-1:0]    c_addr,
  input  logic [CLIENTS*DATA_WIDTH-1:0]    c_wr_data,
  output logic [CLIENTS*DATA_WIDTH-1:0]    c_rd_data,
  output logic [CLIENTS-1:0]               c_ack,
  output logic                             m_rd,
  output logic                             m_wr,
  output logic [ADDR_WIDTH-1:0]            m_addr,
  output logic [DATA_WIDTH-1:0]            m_wr_data,
  input  logic [DATA_WIDTH-1:0]            m_rd_data,
  input  logic                             m_ack
);

  localparam int AW = ADDR_WIDTH;
  localparam int DW = DATA_WIDTH;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t state_q, state_d;

  logic               mode;
  logic [CLIENTS-1:0] enable;
  logic [3:0]         last_grant;
  logic [3:0]         grant;

  logic [CLIENTS-1:0] req;
  logic               hi_found, lo_found, win_found;
  logic [3:0]         hi_idx, lo_idx, win_idx;
  logic               sel_rd, sel_wr;
  logic [AW-1:0]      sel_addr;
  logic [DW-1:0]      sel_wdata;
  logic               do_grant;
  logic               ack_valid;

  logic               apb_access, wr_acc, rd_acc;
  logic               hit_ctrl, hit_en, hit_status, mapped;
  logic [31:0]        wmask;
  logic [CLIENTS-1:0] stat_sel;
  logic [31:0]        stat_rdata;
  logic               unused_bits;

  assign req       = (c_rd | c_wr) & enable;
  assign ack_valid = (state_q == BUSY) && m_ack && (m_rd || m_wr);

  // Round-robin is "lowest requester above last_grant, else lowest overall";
  // fixed priority is just the second half of that.
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_found = 1'b0;
    lo_idx   = '0;
    for (int i = CLIENTS - 1; i >= 0; i--) begin
      if (req[i]) begin
        lo_found = 1'b1;
        lo_idx   = 4'(i);
        if (4'(i) > last_grant) begin
          hi_found = 1'b1;
          hi_idx   = 4'(i);
        end
      end
    end
    win_found = lo_found;
    win_idx   = (mode && hi_found) ? hi_idx : lo_idx;
  end

  always_comb begin
    sel_rd    = 1'b0;
    sel_wr    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < CLIENTS; i++) begin
      if (win_idx == 4'(i)) begin
        sel_rd    = c_rd[i];
        sel_wr    = c_wr[i];
        sel_addr  = c_addr[i*AW +: AW];
        sel_wdata = c_wr_data[i*DW +: DW];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    do_grant = 1'b0;
    case (state_q)
      IDLE: begin
        if (stable && win_found) begin
          do_grant = 1'b1;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        if (ack_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      m_rd       <= 1'b0;
      m_wr       <= 1'b0;
      m_addr     <= '0;
      m_wr_data  <= '0;
      grant      <= '0;
      last_grant <= 4'(CLIENTS - 1);
    end else begin
      state_q <= state_d;
      if (do_grant) begin
        m_rd       <= sel_rd & ~sel_wr;
        m_wr       <= sel_wr;
        m_addr     <= sel_addr;
        m_wr_data  <= sel_wdata;
        grant      <= win_idx;
        last_grant <= win_idx;
      end else if (ack_valid) begin
        m_rd <= 1'b0;
        m_wr <= 1'b0;
      end
    end
  end

  always_comb begin
    c_ack     = '0;
    c_rd_data = '0;
    for (int i = 0; i < CLIENTS; i++) begin
      if (ack_valid && grant == 4'(i)) begin
        c_ack[i]              = 1'b1;
        c_rd_data[i*DW +: DW] = m_rd_data;
      end
    end
  end

  assign apb_access  = conf_sel & conf_enable;
  assign wr_acc      = apb_access & conf_wr;
  assign rd_acc      = apb_access & ~conf_wr;
  assign hit_ctrl    = (conf_addr == 32'h0000_0000);
  assign hit_en      = (conf_addr == 32'h0000_0004);
  assign hit_status  = (conf_addr == 32'h0000_0008);
  assign mapped      = hit_ctrl | hit_en | hit_status | (|stat_sel);
  assign conf_ready  = apb_access;
  assign conf_slverr = apb_access & ~mapped;
  assign wmask       = {{8{conf_strb[3]}}, {8{conf_strb[2]}}, {8{conf_strb[1]}}, {8{conf_strb[0]}}};
  assign unused_bits = ^{conf_wdata, wmask};

  always_ff @(posedge clk) begin
    if (rst) begin
      mode   <= 1'b0;
      enable <= '1;
    end else if (wr_acc) begin
      if (hit_ctrl && conf_strb[0]) mode <= conf_wdata[0];
      if (hit_en) enable <= (enable & ~wmask[CLIENTS-1:0]) |
                            (conf_wdata[CLIENTS-1:0] & wmask[CLIENTS-1:0]);
    end
  end

  always_comb begin
    conf_rdata = '0;
    if (rd_acc) begin
      if (hit_ctrl)        conf_rdata = {31'b0, mode};
      else if (hit_en)     conf_rdata = 32'(enable);
      else if (hit_status) conf_rdata = {20'b0, last_grant, 7'b0, (state_q == BUSY)};
      else                 conf_rdata = stat_rdata;
    end
  end

`ifdef MEM_ARB_N_STATS_EN
  logic [31:0] stat_cnt [CLIENTS];

  always_comb begin
    stat_sel   = '0;
    stat_rdata = '0;
    for (int i = 0; i < CLIENTS; i++) begin
      if (conf_addr == 32'(16 + 4 * i)) begin
        stat_sel[i] = 1'b1;
        stat_rdata  = stat_cnt[i];
      end
    end
  end

  // A clear from APB beats an increment landing in the same cycle.
  always_ff @(posedge clk) begin
    for (int i = 0; i < CLIENTS; i++) begin
      if (rst)                        stat_cnt[i] <= '0;
      else if (wr_acc && stat_sel[i]) stat_cnt[i] <= '0;
      else if (c_ack[i])              stat_cnt[i] <= stat_cnt[i] + 32'd1;
    end
  end
`else
  assign stat_sel   = '0;
  assign stat_rdata = '0;
`endif

endmodule
